// File: rtl/invert_serial.sv
// ---------------------------------------------------------------------------
// invert_serial
//
// Bit-serial two's-complement negation. One operand bit arrives per clock,
// LSB first, and the negated bit leaves combinationally in the same cycle.
// Bits up to and including the first 1 of a word pass through unchanged.
// Every later bit of that word is inverted.
//
// Parameters:
//   WORD_LEN : bits per word. 0 means unbounded, so a word ends only on r.
//              N > 0 means the state restarts automatically after every
//              N bits.
//
// Ports:
//   i     : serial operand bit, LSB first, sampled on every rising edge
//   r     : synchronous active-high reset; it also starts a new word
//   t_clk : clock, rising-edge active
//   y     : serial result bit, valid in the same cycle as i; 0 while r=1
// ---------------------------------------------------------------------------
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_PASS    | no 1 has passed yet in this word, so y = i
// ST_INVERT  | a 1 has already passed in this word, so y = ~i
//
module invert_serial #(
    parameter int unsigned WORD_LEN = 0
) (
    input  logic i,
    input  logic r,
    input  logic t_clk,
    output logic y
);

    typedef enum logic {
        ST_PASS   = 1'b0,
        ST_INVERT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // High on the last bit of a bounded word. It is always low when
    // WORD_LEN is 0.
    logic   word_end;

    generate
        if (WORD_LEN > 0) begin : g_cnt
            localparam int unsigned CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_LEN - 1);

            logic [CNT_W-1:0] cnt;

            always_ff @(posedge t_clk) begin
                if (r) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            assign word_end = (cnt == CNT_LAST);
        end else begin : g_nocnt
            assign word_end = 1'b0;
        end
    endgenerate

    always_ff @(posedge t_clk) begin
        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        y         = 1'b0;
        if (r) begin
            // A reset cycle ignores i. It also abandons any partial word.
            state_nxt = ST_PASS;
        end else begin
            case (state)
                ST_PASS: begin
                    y = i;
                    if (i) begin
                        state_nxt = ST_INVERT;
                    end
                end
                ST_INVERT: begin
                    y = ~i;
                end
                default: begin
                    y         = 1'b0;
                    state_nxt = ST_PASS;
                end
            endcase
            // The end-of-word restart takes precedence over a 1 in the last bit.
            if (word_end) begin
                state_nxt = ST_PASS;
            end
        end
    end

endmodule

// File: tb/tb_invert_serial.sv
module tb_invert_serial;

    logic t_clk;
    logic i0, r0, y0;
    logic i4, r4, y4;

    int checks   = 0;
    int failures = 0;

    invert_serial #(.WORD_LEN(0)) dut0 (
        .i     (i0),
        .r     (r0),
        .t_clk (t_clk),
        .y     (y0)
    );

    invert_serial #(.WORD_LEN(4)) dut4 (
        .i     (i4),
        .r     (r4),
        .t_clk (t_clk),
        .y     (y4)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    // Drive one bit mid-cycle, check y before the next rising edge.
    // sel=0 drives the unbounded instance, sel=4 the WORD_LEN=4 instance.
    task automatic step(input int sel, input logic iv, input logic rv,
                        input logic exp, input string tag);
        logic obs;
        @(negedge t_clk);
        if (sel == 0) begin
            i0 = iv;
            r0 = rv;
        end else begin
            i4 = iv;
            r4 = rv;
        end
        #1;
        obs = (sel == 0) ? y0 : y4;
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: y=%0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        i0 = 1'b0;
        r0 = 1'b1;
        i4 = 1'b0;
        r4 = 1'b1;

        // Unbounded words. 6 = 0110 gives 10 = 1010 (LSB first).
        step(0, 1'b0, 1'b1, 1'b0, "u_rst0");
        step(0, 1'b0, 1'b0, 1'b0, "u6_b0");
        step(0, 1'b1, 1'b0, 1'b1, "u6_b1");
        step(0, 1'b1, 1'b0, 1'b0, "u6_b2");
        step(0, 1'b0, 1'b0, 1'b1, "u6_b3");

        // An all-zero word gives zero, and seen stays clear afterwards.
        step(0, 1'b1, 1'b1, 1'b0, "u_rst1");
        step(0, 1'b0, 1'b0, 1'b0, "u0_b0");
        step(0, 1'b0, 1'b0, 1'b0, "u0_b1");
        step(0, 1'b0, 1'b0, 1'b0, "u0_b2");
        step(0, 1'b0, 1'b0, 1'b0, "u0_b3");
        step(0, 1'b1, 1'b0, 1'b1, "u0_seen_clear");

        // 15 gives 1.
        step(0, 1'b1, 1'b1, 1'b0, "u_rst2");
        step(0, 1'b1, 1'b0, 1'b1, "u15_b0");
        step(0, 1'b1, 1'b0, 1'b0, "u15_b1");
        step(0, 1'b1, 1'b0, 1'b0, "u15_b2");
        step(0, 1'b1, 1'b0, 1'b0, "u15_b3");

        // Reset in the middle of a word clears seen.
        step(0, 1'b0, 1'b1, 1'b0, "u_rst3");
        step(0, 1'b1, 1'b0, 1'b1, "um_b0");
        step(0, 1'b1, 1'b1, 1'b0, "um_rst");
        step(0, 1'b1, 1'b0, 1'b1, "um_new_b0");
        step(0, 1'b0, 1'b0, 1'b1, "um_new_b1");

        // r held high for three edges while i toggles.
        step(0, 1'b1, 1'b1, 1'b0, "uh_r0");
        step(0, 1'b0, 1'b1, 1'b0, "uh_r1");
        step(0, 1'b1, 1'b1, 1'b0, "uh_r2");
        step(0, 1'b1, 1'b0, 1'b1, "uh_first1");
        step(0, 1'b1, 1'b0, 1'b0, "uh_next");

        // WORD_LEN=4. Two words of value 2 each give 14 (0111 LSB first).
        step(4, 1'b0, 1'b1, 1'b0, "w_rst0");
        step(4, 1'b0, 1'b0, 1'b0, "w2a_b0");
        step(4, 1'b1, 1'b0, 1'b1, "w2a_b1");
        step(4, 1'b0, 1'b0, 1'b1, "w2a_b2");
        step(4, 1'b0, 1'b0, 1'b1, "w2a_b3");
        step(4, 1'b0, 1'b0, 1'b0, "w2b_b0");
        step(4, 1'b1, 1'b0, 1'b1, "w2b_b1");
        step(4, 1'b0, 1'b0, 1'b1, "w2b_b2");
        step(4, 1'b0, 1'b0, 1'b1, "w2b_b3");

        // 1 gives 15, then MSB-only (8) gives itself.
        step(4, 1'b1, 1'b0, 1'b1, "w1_b0");
        step(4, 1'b0, 1'b0, 1'b1, "w1_b1");
        step(4, 1'b0, 1'b0, 1'b1, "w1_b2");
        step(4, 1'b0, 1'b0, 1'b1, "w1_b3");
        step(4, 1'b0, 1'b0, 1'b0, "w8_b0");
        step(4, 1'b0, 1'b0, 1'b0, "w8_b1");
        step(4, 1'b0, 1'b0, 1'b0, "w8_b2");
        step(4, 1'b1, 1'b0, 1'b1, "w8_b3");

        // A mid-word reset must also restart the bit counter.
        step(4, 1'b1, 1'b0, 1'b1, "wm_b0");
        step(4, 1'b1, 1'b1, 1'b0, "wm_rst");
        step(4, 1'b0, 1'b0, 1'b0, "wm6_b0");
        step(4, 1'b1, 1'b0, 1'b1, "wm6_b1");
        step(4, 1'b1, 1'b0, 1'b0, "wm6_b2");
        step(4, 1'b0, 1'b0, 1'b1, "wm6_b3");
        step(4, 1'b1, 1'b0, 1'b1, "wm_next_b0");
        step(4, 1'b1, 1'b0, 1'b0, "wm_next_b1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
